brush_painter: RTL and testbench

Draw-path stage directly downstream of the pen colour selector. It takes the cursor position, the pen-down request, the 3-bit pen colour and the brush size, and turns each stroke request into a sequence of single-pixel writes into the canvas frame-buffer write port. It clips writes at the canvas edges and suppresses redundant rewrites. It can also optionally wipe the whole canvas.

---
 rtl/canvas_pkg.sv | 32 +++
 rtl/canvas_addr_gen.sv | 16 +
 rtl/brush_painter.sv | 202 ++++++++++++++++++++
 tb/tb_brush_painter.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/canvas_pkg.sv
// rtl/canvas_pkg.sv - shared canvas colour codes, default geometry and painter state encoding
// CLEAR exists only when BRUSH_PAINTER_CLEAR_EN is defined.
package canvas_pkg;

  localparam logic [2:0] WHITE  = 3'b000;
  localparam logic [2:0] RED    = 3'b001;
  localparam logic [2:0] ORANGE = 3'b010;
  localparam logic [2:0] YELLOW = 3'b011;
  localparam logic [2:0] GREEN  = 3'b100;
  localparam logic [2:0] BLUE   = 3'b101;
  localparam logic [2:0] PURPLE = 3'b110;
  localparam logic [2:0] BLACK  = 3'b111;

  localparam int unsigned DEFAULT_CANVAS_W = 160;
  localparam int unsigned DEFAULT_CANVAS_H = 120;

`ifdef BRUSH_PAINTER_CLEAR_EN
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PAINT = 2'd1,
    CLEAR = 2'd2,
    DONE  = 2'd3
  } painter_state_t;
`else
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PAINT = 2'd1,
    DONE  = 2'd3
  } painter_state_t;
`endif

endpackage

// File: rtl/canvas_addr_gen.sv
// rtl/canvas_addr_gen.sv - maps a pixel (px, py) to a frame-buffer address and flags on-canvas pixels
module canvas_addr_gen #(
  parameter int unsigned CANVAS_W = 160,
  parameter int unsigned CANVAS_H = 120,
  parameter int unsigned ADDR_W   = 15
) (
  input  logic [8:0]        px,
  input  logic [7:0]        py,
  output logic [ADDR_W-1:0] addr,
  output logic              in_range
);

  assign in_range = ({23'b0, px} < CANVAS_W) && ({24'b0, py} < CANVAS_H);
  assign addr     = ADDR_W'({24'b0, py} * CANVAS_W + {23'b0, px});

endmodule

// File: rtl/brush_painter.sv
// rtl/brush_painter.sv - expands pen strokes into clipped, deduplicated single-pixel frame-buffer writes
// Optional full-canvas wipe compiled in with BRUSH_PAINTER_CLEAR_EN.
module brush_painter
  import canvas_pkg::*;
#(
  parameter int unsigned CANVAS_W = DEFAULT_CANVAS_W,
  parameter int unsigned CANVAS_H = DEFAULT_CANVAS_H,
  parameter int unsigned ADDR_W   = 15
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              pen_down,
  input  logic [7:0]        cur_x,
  input  logic [6:0]        cur_y,
  input  logic [2:0]        color,
  input  logic [1:0]        brush_size,
  input  logic              clear_req,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [2:0]        wr_data,
  input  logic              wr_ready,
  output logic              busy,
  output logic              done
);

  painter_state_t state, nxt_state;
  logic [7:0] x0, nxt_x0, last_x;
  logic [6:0] y0, nxt_y0, last_y;
  logic [2:0] col, nxt_col, last_col;
  logic [1:0] sz, nxt_sz, last_sz;
  logic [1:0] dx, nxt_dx, dy, nxt_dy;
  logic       last_valid, stroke_end, clear_end, advance, same_stroke;

  logic              wr_en_d, busy_d, done_d;
  logic [ADDR_W-1:0] wr_addr_d, pix_addr;
  logic [2:0]        wr_data_d;
  logic              pix_in_range;

`ifdef BRUSH_PAINTER_CLEAR_EN
  localparam logic [ADDR_W-1:0] CLR_LAST = ADDR_W'(CANVAS_W * CANVAS_H - 1);
  logic [ADDR_W-1:0] clr_addr, nxt_clr_addr;
`else
  logic unused_clear_req;
  assign unused_clear_req = clear_req;
`endif

  // Address is generated for the pixel the outputs will present after this edge.
  canvas_addr_gen #(
    .CANVAS_W (CANVAS_W),
    .CANVAS_H (CANVAS_H),
    .ADDR_W   (ADDR_W)
  ) u_addr_gen (
    .px       ({1'b0, nxt_x0} + {7'b0, nxt_dx}),
    .py       ({1'b0, nxt_y0} + {6'b0, nxt_dy}),
    .addr     (pix_addr),
    .in_range (pix_in_range)
  );

  assign same_stroke = last_valid && (cur_x == last_x) && (cur_y == last_y) &&
                       (color == last_col) && (brush_size == last_sz);
  // A skipped pixel has wr_en low and always advances; a real write waits for wr_ready.
  assign advance = !wr_en || wr_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      x0         <= '0;
      y0         <= '0;
      col        <= '0;
      sz         <= '0;
      dx         <= '0;
      dy         <= '0;
      last_x     <= '0;
      last_y     <= '0;
      last_col   <= '0;
      last_sz    <= '0;
      last_valid <= 1'b0;
      wr_en      <= 1'b0;
      wr_addr    <= '0;
      wr_data    <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
`ifdef BRUSH_PAINTER_CLEAR_EN
      clr_addr   <= '0;
`endif
    end else begin
      state   <= nxt_state;
      x0      <= nxt_x0;
      y0      <= nxt_y0;
      col     <= nxt_col;
      sz      <= nxt_sz;
      dx      <= nxt_dx;
      dy      <= nxt_dy;
      wr_en   <= wr_en_d;
      wr_addr <= wr_addr_d;
      wr_data <= wr_data_d;
      busy    <= busy_d;
      done    <= done_d;
`ifdef BRUSH_PAINTER_CLEAR_EN
      clr_addr <= nxt_clr_addr;
`endif
      if (stroke_end) begin
        last_x     <= x0;
        last_y     <= y0;
        last_col   <= col;
        last_sz    <= sz;
        last_valid <= 1'b1;
      end else if (clear_end) begin
        last_valid <= 1'b0;
      end
    end
  end

  always_comb begin
    nxt_state  = state;
    nxt_x0     = x0;
    nxt_y0     = y0;
    nxt_col    = col;
    nxt_sz     = sz;
    nxt_dx     = dx;
    nxt_dy     = dy;
    stroke_end = 1'b0;
    clear_end  = 1'b0;
`ifdef BRUSH_PAINTER_CLEAR_EN
    nxt_clr_addr = clr_addr;
`endif
    case (state)
      IDLE: begin
`ifdef BRUSH_PAINTER_CLEAR_EN
        if (clear_req) begin
          nxt_state    = CLEAR;
          nxt_clr_addr = '0;
        end else
`endif
        if (pen_down && !same_stroke) begin
          nxt_state = PAINT;
          nxt_x0    = cur_x;
          nxt_y0    = cur_y;
          nxt_col   = color;
          nxt_sz    = brush_size;
          nxt_dx    = '0;
          nxt_dy    = '0;
        end
      end
      PAINT: begin
        if (advance) begin
          if (dx == sz) begin
            nxt_dx = '0;
            if (dy == sz) begin
              nxt_state  = DONE;
              stroke_end = 1'b1;
            end else begin
              nxt_dy = dy + 2'd1;
            end
          end else begin
            nxt_dx = dx + 2'd1;
          end
        end
      end
`ifdef BRUSH_PAINTER_CLEAR_EN
      CLEAR: begin
        if (wr_ready) begin
          if (clr_addr == CLR_LAST) begin
            nxt_state = DONE;
            clear_end = 1'b1;
          end else begin
            nxt_clr_addr = clr_addr + ADDR_W'(1);
          end
        end
      end
`endif
      DONE:    nxt_state = IDLE;
      default: nxt_state = IDLE;
    endcase
  end

  always_comb begin
    wr_en_d   = 1'b0;
    wr_addr_d = '0;
    wr_data_d = '0;
    busy_d    = (nxt_state != IDLE);
    done_d    = (nxt_state == DONE);
    case (nxt_state)
      PAINT: begin
        if (pix_in_range) begin
          wr_en_d   = 1'b1;
          wr_addr_d = pix_addr;
          wr_data_d = nxt_col;
        end
      end
`ifdef BRUSH_PAINTER_CLEAR_EN
      CLEAR: begin
        wr_en_d   = 1'b1;
        wr_addr_d = nxt_clr_addr;
        wr_data_d = WHITE;
      end
`endif
      default: ;
    endcase
  end

endmodule

// File: tb/tb_brush_painter.sv
// tb/tb_brush_painter.sv - directed self-checking bench for brush_painter
module tb_brush_painter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        pen_down = 1'b0;
  logic [7:0]  cur_x = '0;
  logic [6:0]  cur_y = '0;
  logic [2:0]  color = '0;
  logic [1:0]  brush_size = '0;
  logic        clear_req = 1'b0;
  logic        wr_en;
  logic [14:0] wr_addr;
  logic [2:0]  wr_data;
  logic        wr_ready = 1'b1;
  logic        busy;
  logic        done;

  int checks = 0;
  int failures = 0;
  int done_cnt = 0;
  int hold_err = 0;
  logic [17:0] wq[$];
  logic        stall_prev = 1'b0;
  logic [14:0] prev_addr = '0;
  logic [2:0]  prev_data = '0;

  brush_painter dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .pen_down   (pen_down),
    .cur_x      (cur_x),
    .cur_y      (cur_y),
    .color      (color),
    .brush_size (brush_size),
    .clear_req  (clear_req),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .wr_ready   (wr_ready),
    .busy       (busy),
    .done       (done)
  );

  always #5 clk = ~clk;

  // Transfers happen on the next rising edge; inputs only change #1 after a rising edge.
  always @(negedge clk) begin
    if (rst_n && stall_prev &&
        !(wr_en && wr_addr == prev_addr && wr_data == prev_data))
      hold_err++;
    stall_prev = rst_n && wr_en && !wr_ready;
    prev_addr  = wr_addr;
    prev_data  = wr_data;
    if (rst_n && wr_en && wr_ready) wq.push_back({wr_data, wr_addr});
    if (rst_n && done) done_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_done(input string tag, input int max, output int n);
    n = 0;
    while (!done && n < max) begin
      tick();
      n++;
    end
    check({tag, "_timeout"}, {31'b0, done}, 32'd1);
  endtask

  task automatic stroke(input logic [7:0] x, input logic [6:0] y, input logic [2:0] c,
                        input logic [1:0] s);
    cur_x = x;
    cur_y = y;
    color = c;
    brush_size = s;
    pen_down = 1'b1;
    tick();
    pen_down = 1'b0;
  endtask

  initial begin
    int n;
    int bad;
    #2 rst_n = 1'b0;
    tick();
    check("rst_wr_en", {31'b0, wr_en}, 0);
    check("rst_wr_addr", {17'b0, wr_addr}, 0);
    check("rst_wr_data", {29'b0, wr_data}, 0);
    check("rst_busy", {31'b0, busy}, 0);
    check("rst_done", {31'b0, done}, 0);
    rst_n = 1'b1;
    tick(); tick();
    check("idle_after_rst", {31'b0, busy}, 0);

    // 2x2 red brush at (10,20)
    wq.delete();
    stroke(8'd10, 7'd20, 3'b001, 2'd1);
    check("s1_first_wr_en", {31'b0, wr_en}, 1);
    check("s1_first_addr", {17'b0, wr_addr}, 3210);
    check("s1_busy", {31'b0, busy}, 1);
    wait_done("s1", 20, n);
    check("s1_cycles", n, 4);
    check("s1_busy_at_done", {31'b0, busy}, 1);
    tick();
    check("s1_done_pulse", {31'b0, done}, 0);
    check("s1_busy_fall", {31'b0, busy}, 0);
    check("s1_nwrites", wq.size(), 4);
    check("s1_w0", {14'b0, wq[0]}, {14'b0, 3'd1, 15'd3210});
    check("s1_w1", {14'b0, wq[1]}, {14'b0, 3'd1, 15'd3211});
    check("s1_w2", {14'b0, wq[2]}, {14'b0, 3'd1, 15'd3370});
    check("s1_w3", {14'b0, wq[3]}, {14'b0, 3'd1, 15'd3371});

    // 4x4 at the bottom-right corner: only one pixel on canvas
    wq.delete();
    stroke(8'd159, 7'd119, 3'b111, 2'd3);
    wait_done("corner", 40, n);
    check("corner_cycles", n, 16);
    tick();
    check("corner_nwrites", wq.size(), 1);
    check("corner_w0", {14'b0, wq[0]}, {14'b0, 3'd7, 15'd19199});

    // single pixel under backpressure
    wq.delete();
    wr_ready = 1'b0;
    stroke(8'd0, 7'd0, 3'b010, 2'd0);
    check("bp_wr_en", {31'b0, wr_en}, 1);
    tick();
    wr_ready = 1'b1;
    tick();
    check("bp_done_early", {31'b0, done}, 1);
    wr_ready = 1'b0;
    tick(); tick();
    tick();
    wr_ready = 1'b1;
    check("bp_nwrites", wq.size(), 1);
    check("bp_w0", {14'b0, wq[0]}, {14'b0, 3'd2, 15'd0});

    // second single pixel with a longer stall
    wq.delete();
    wr_ready = 1'b0;
    stroke(8'd1, 7'd0, 3'b010, 2'd0);
    tick(); tick(); tick();
    check("bp2_held_en", {31'b0, wr_en}, 1);
    check("bp2_held_addr", {17'b0, wr_addr}, 1);
    check("bp2_held_data", {29'b0, wr_data}, 2);
    wr_ready = 1'b1;
    wait_done("bp2", 10, n);
    check("bp2_cycles", n, 1);
    tick();
    check("bp2_nwrites", wq.size(), 1);

    // reset in the middle of a 4x4 stroke
    stroke(8'd5, 7'd5, 3'b100, 2'd3);
    tick();
    check("mid_wr_addr", {17'b0, wr_addr}, 806);
    rst_n = 1'b0;
    #1;
    check("mid_rst_wr_en", {31'b0, wr_en}, 0);
    check("mid_rst_busy", {31'b0, busy}, 0);
    check("mid_rst_addr", {17'b0, wr_addr}, 0);
    tick();
    rst_n = 1'b1;
    tick(); tick();
    check("mid_no_resume", {31'b0, busy}, 0);

    // held pen_down: one stroke, then one more after a colour change
    wq.delete();
    done_cnt = 0;
    cur_x = 8'd3; cur_y = 7'd3; color = 3'b011; brush_size = 2'd1;
    pen_down = 1'b1;
    repeat (50) tick();
    check("hold_strokes", done_cnt, 1);
    check("hold_nwrites", wq.size(), 4);
    check("hold_w0", {14'b0, wq[0]}, {14'b0, 3'd3, 15'd483});
    color = 3'b101;
    repeat (50) tick();
    check("recolor_strokes", done_cnt, 2);
    check("recolor_nwrites", wq.size(), 8);
    check("recolor_w7", {14'b0, wq[7]}, {14'b0, 3'd5, 15'd644});

`ifdef BRUSH_PAINTER_CLEAR_EN
    // wipe has priority, then the still-held stroke repaints since dedup was reset
    wq.delete();
    clear_req = 1'b1;
    tick();
    clear_req = 1'b0;
    check("clr_first", {31'b0, wr_en}, 1);
    wait_done("clr", 20000, n);
    check("clr_cycles", n, 19200);
    check("clr_nwrites", wq.size(), 19200);
    bad = 0;
    for (int i = 0; i < 19200 && i < wq.size(); i++)
      if (wq[i] !== {3'd0, 15'(i)}) bad++;
    check("clr_seq", bad, 0);
    tick();
    wait_done("clr_stroke", 20, n);
    tick();
    check("clr_stroke_nwrites", wq.size(), 19204);
    check("clr_stroke_w0", {14'b0, wq[19200]}, {14'b0, 3'd5, 15'd483});
    check("clr_stroke_w3", {14'b0, wq[19203]}, {14'b0, 3'd5, 15'd644});
`endif
    pen_down = 1'b0;
    tick();

    check("hold_stable", hold_err, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
